gen_matrix_sched: RTL and testbench

Sequences generation of the Kyber public matrix A (KYBER_K x KYBER_K polynomials) by driving the SHAKE128 XOF block and the rejection-uniform sampler.
- For each (row, col) pair it requests an XOF squeeze with the correct index bytes.
- It then clears and enables the sampler and presents each finished polynomial to the downstream consumer with a valid/ready handshake.
- It sits between the key-gen/encrypt top-level FSM and the XOF + rejection-sampler datapath.

---
 rtl/gen_matrix_sched.sv | 149 ++++++++++++++
 tb/tb_gen_matrix_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_matrix_sched.sv
// Sequencer for Kyber matrix A generation: walks (row, col) in row-major order,
// drives one XOF squeeze and one rejection-sampler pass per polynomial, then hands it off.
module gen_matrix_sched #(
  parameter int KYBER_K = 2,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start,
  input  logic             transposed,
  output logic             busy,
  output logic             done,
  output logic             xof_start,
  output logic [IDX_W-1:0] xof_idx_x,
  output logic [IDX_W-1:0] xof_idx_y,
  input  logic             xof_done,
  output logic             ru_clear,
  output logic             ru_enable,
  input  logic             ru_done,
  output logic             poly_valid,
  output logic [IDX_W-1:0] poly_row,
  output logic [IDX_W-1:0] poly_col,
  input  logic             poly_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_XOF_REQ, S_XOF_WAIT, S_RU_CLR, S_RU_RUN, S_OUT, S_ADV, S_FIN
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KYBER_K - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic             tr_q, tr_d;
  logic             first_q, first_d;

  logic             busy_d, done_d, xof_start_d, ru_clear_d, ru_enable_d, poly_valid_d;
  logic [IDX_W-1:0] idx_x_d, idx_y_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tr_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tr_q    <= tr_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tr_d    = tr_q;
    first_d = first_q;
    if (clear) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      first_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_XOF_REQ;
            tr_d    = transposed;
            row_d   = '0;
            col_d   = '0;
          end
        end
        S_XOF_REQ:  state_d = S_XOF_WAIT;
        S_XOF_WAIT: if (xof_done) state_d = S_RU_CLR;
        S_RU_CLR: begin
          state_d = S_RU_RUN;
          first_d = 1'b1;
        end
        // ru_done may still reflect the previous poly on the cycle right after the clear
        S_RU_RUN: begin
          first_d = 1'b0;
          if (!first_q && ru_done) state_d = S_OUT;
        end
        S_OUT: if (poly_valid && poly_ready) state_d = S_ADV;
        S_ADV: begin
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              row_d   = '0;
              state_d = S_FIN;
            end else begin
              row_d   = row_q + IDX_W'(1);
              state_d = S_XOF_REQ;
            end
          end else begin
            col_d   = col_q + IDX_W'(1);
            state_d = S_XOF_REQ;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
    xof_start_d  = (state_d == S_XOF_REQ);
    ru_clear_d   = (state_d == S_RU_CLR);
    ru_enable_d  = (state_d == S_RU_RUN);
    poly_valid_d = (state_d == S_OUT);
    idx_x_d      = tr_d ? row_d : col_d;
    idx_y_d      = tr_d ? col_d : row_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      xof_start  <= 1'b0;
      xof_idx_x  <= '0;
      xof_idx_y  <= '0;
      ru_clear   <= 1'b0;
      ru_enable  <= 1'b0;
      poly_valid <= 1'b0;
      poly_row   <= '0;
      poly_col   <= '0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      xof_start  <= xof_start_d;
      xof_idx_x  <= idx_x_d;
      xof_idx_y  <= idx_y_d;
      ru_clear   <= ru_clear_d;
      ru_enable  <= ru_enable_d;
      poly_valid <= poly_valid_d;
      poly_row   <= row_d;
      poly_col   <= col_d;
    end
  end

endmodule

// File: tb/tb_gen_matrix_sched.sv
// Directed bench for gen_matrix_sched with behavioural XOF, sampler and consumer responders.
module tb_gen_matrix_sched;

  logic       clk = 1'b0;
  logic       reset_n, clear, start, transposed;
  logic       xof_done, ru_done, poly_ready;
  logic       busy, done, xof_start, ru_clear, ru_enable, poly_valid;
  logic [7:0] xof_idx_x, xof_idx_y, poly_row, poly_col;

  gen_matrix_sched #(.KYBER_K(2), .IDX_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .transposed(transposed),
    .busy(busy), .done(done), .xof_start(xof_start), .xof_idx_x(xof_idx_x),
    .xof_idx_y(xof_idx_y), .xof_done(xof_done), .ru_clear(ru_clear), .ru_enable(ru_enable),
    .ru_done(ru_done), .poly_valid(poly_valid), .poly_row(poly_row), .poly_col(poly_col),
    .poly_ready(poly_ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int xof_lat = 0, ru_lat = 0, xof_cnt = 0, ru_en_cnt = 0, bp_cnt = 0;
  bit stale_ru = 0, bp_en = 0, glitch_en = 0;
  logic cur_tr = 1'b0;

  int n_xs, n_hs, n_done, n_ruclr, min_en, en_run, v01_cnt, unstable, xs_in_valid, idx_drift;
  int cyc_cnt, done_cyc, busy_at_done;
  logic [7:0] xs_x [16], xs_y [16], hs_r [16], hs_c [16];
  logic prev_valid = 0, prev_hs = 0;
  logic [7:0] prev_row = 0, prev_col = 0;

  // Responders and monitor, all acting on the falling edge
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      xof_done = 0; ru_done = 0; xof_cnt = 0; ru_en_cnt = 0; poly_ready = 1;
      prev_valid = 0; prev_hs = 0;
    end else begin
      xof_done = 0;
      if (xof_cnt > 0) begin
        xof_cnt--;
        if (xof_cnt == 0) xof_done = 1;
      end
      if (xof_start) xof_cnt = xof_lat + 1;
      if (ru_clear) begin
        ru_done = 0; ru_en_cnt = 0;
      end else if (ru_enable) begin
        ru_en_cnt++;
        if (ru_en_cnt > ru_lat) ru_done = 1;
      end
      if (stale_ru) ru_done = 1;
      if (glitch_en && (!busy || poly_valid)) begin
        xof_done = 1; ru_done = 1;
      end
      poly_ready = 1;
      if (bp_en && poly_valid && poly_row == 0 && poly_col == 1 && bp_cnt < 10) begin
        poly_ready = 0; bp_cnt++;
      end
      if (xof_start) begin
        if (poly_valid) xs_in_valid++;
        if (n_xs < 16) begin xs_x[n_xs] = xof_idx_x; xs_y[n_xs] = xof_idx_y; end
        n_xs++;
      end
      if (poly_valid && poly_ready) begin
        if (n_hs < 16) begin hs_r[n_hs] = poly_row; hs_c[n_hs] = poly_col; end
        n_hs++;
        if (xof_idx_x != (cur_tr ? poly_row : poly_col) ||
            xof_idx_y != (cur_tr ? poly_col : poly_row)) idx_drift++;
      end
      if (poly_valid && poly_row == 0 && poly_col == 1) v01_cnt++;
      if (prev_valid && !prev_hs && poly_valid && (poly_row != prev_row || poly_col != prev_col))
        unstable++;
      if (prev_hs && poly_valid) unstable++;
      if (done) begin n_done++; done_cyc = cyc_cnt; busy_at_done = busy; end
      if (ru_clear) n_ruclr++;
      if (ru_enable) en_run++;
      else if (en_run > 0) begin
        if (en_run < min_en) min_en = en_run;
        en_run = 0;
      end
      cyc_cnt++;
      prev_valid = poly_valid; prev_hs = poly_valid && poly_ready;
      prev_row = poly_row; prev_col = poly_col;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon;
    n_xs = 0; n_hs = 0; n_done = 0; n_ruclr = 0; min_en = 1000; en_run = 0;
    v01_cnt = 0; unstable = 0; xs_in_valid = 0; idx_drift = 0;
    cyc_cnt = 0; done_cyc = -1; busy_at_done = 0;
  endtask

  task automatic run_matrix(input logic tr, input bit glitch);
    tick;
    clr_mon();
    cur_tr = tr; transposed = tr; start = 1;
    tick;
    start = 0; transposed = ~tr;
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      tick;
      start = glitch && busy && !done && (i % 3 == 1);
    end
    start = 0;
    tick;
  endtask

  task automatic test_reset;
    reset_n = 0; clear = 0; start = 0; transposed = 0;
    repeat (3) tick;
    total++;
    if ({busy, done, xof_start, xof_idx_x, xof_idx_y, ru_clear, ru_enable, poly_valid,
         poly_row, poly_col} !== 38'd0)
      begin bad++; $display("FAIL reset_outputs busy=%b valid=%b x=%0d", busy, poly_valid, xof_idx_x); end
    reset_n = 1;
    repeat (2) tick;
    total++;
    if (busy !== 1'b0 || xof_start !== 1'b0)
      begin bad++; $display("FAIL idle_after_reset busy=%b xof_start=%b exp 0", busy, xof_start); end
  endtask

  task automatic test_normal;
    run_matrix(1'b0, 0);
    total++;
    if (n_done !== 1 || done_cyc !== 28 || busy_at_done !== 1)
      begin bad++; $display("FAIL normal_done count=%0d cyc=%0d busy=%0d exp 1/28/1", n_done, done_cyc, busy_at_done); end
    total++;
    if (busy !== 1'b0)
      begin bad++; $display("FAIL normal_busy_after got=%b exp 0", busy); end
    total++;
    if (n_xs !== 4 || n_hs !== 4)
      begin bad++; $display("FAIL normal_counts xof=%0d hs=%0d exp 4/4", n_xs, n_hs); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (xs_x[i] !== 8'(i % 2) || xs_y[i] !== 8'(i / 2))
        begin bad++; $display("FAIL normal_xof_idx[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, xs_x[i], xs_y[i], i % 2, i / 2); end
      total++;
      if (hs_r[i] !== 8'(i / 2) || hs_c[i] !== 8'(i % 2))
        begin bad++; $display("FAIL normal_hs[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, hs_r[i], hs_c[i], i / 2, i % 2); end
    end
    total++;
    if (min_en !== 2 || n_ruclr !== 4 || idx_drift !== 0 || unstable !== 0)
      begin bad++; $display("FAIL normal_misc en=%0d clr=%0d drift=%0d unst=%0d exp 2/4/0/0", min_en, n_ruclr, idx_drift, unstable); end
  endtask

  task automatic test_transposed;
    run_matrix(1'b1, 0);
    total++;
    if (n_done !== 1 || done_cyc !== 28 || n_xs !== 4 || n_hs !== 4)
      begin bad++; $display("FAIL tr_counts done=%0d cyc=%0d xof=%0d hs=%0d", n_done, done_cyc, n_xs, n_hs); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (xs_x[i] !== 8'(i / 2) || xs_y[i] !== 8'(i % 2))
        begin bad++; $display("FAIL tr_xof_idx[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, xs_x[i], xs_y[i], i / 2, i % 2); end
      total++;
      if (hs_r[i] !== 8'(i / 2) || hs_c[i] !== 8'(i % 2))
        begin bad++; $display("FAIL tr_hs[%0d] got=(%0d,%0d) exp=(%0d,%0d)", i, hs_r[i], hs_c[i], i / 2, i % 2); end
    end
    total++;
    if (idx_drift !== 0)
      begin bad++; $display("FAIL tr_idx_drift got=%0d exp 0", idx_drift); end
  endtask

  task automatic test_backpressure;
    bp_en = 1; bp_cnt = 0;
    run_matrix(1'b0, 0);
    bp_en = 0;
    total++;
    if (done_cyc !== 38 || n_hs !== 4 || n_xs !== 4)
      begin bad++; $display("FAIL bp_timing cyc=%0d hs=%0d xof=%0d exp 38/4/4", done_cyc, n_hs, n_xs); end
    total++;
    if (v01_cnt !== 11)
      begin bad++; $display("FAIL bp_valid_hold got=%0d exp 11", v01_cnt); end
    total++;
    if (unstable !== 0 || xs_in_valid !== 0 || idx_drift !== 0)
      begin bad++; $display("FAIL bp_stability unst=%0d xs_in_valid=%0d drift=%0d exp 0", unstable, xs_in_valid, idx_drift); end
  endtask

  task automatic test_latency_stale;
    // ru_done is still high from the previous run here
    xof_lat = 1; ru_lat = 2;
    run_matrix(1'b0, 0);
    xof_lat = 0; ru_lat = 0;
    total++;
    if (done_cyc !== 36 || min_en !== 3 || n_ruclr !== 4)
      begin bad++; $display("FAIL lat_fresh cyc=%0d en=%0d clr=%0d exp 36/3/4", done_cyc, min_en, n_ruclr); end
    stale_ru = 1;
    run_matrix(1'b0, 0);
    stale_ru = 0;
    total++;
    if (done_cyc !== 28 || min_en !== 2 || n_ruclr !== 4 || n_hs !== 4)
      begin bad++; $display("FAIL stale_ru cyc=%0d en=%0d clr=%0d hs=%0d exp 28/2/4/4", done_cyc, min_en, n_ruclr, n_hs); end
  endtask

  task automatic test_clear;
    tick;
    clr_mon();
    cur_tr = 0; transposed = 0; start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 200 && !(ru_enable && poly_row == 1 && poly_col == 0); i++) tick;
    total++;
    if (!(ru_enable === 1'b1 && poly_row === 8'd1 && poly_col === 8'd0))
      begin bad++; $display("FAIL clear_reach_ru_run en=%b row=%0d col=%0d exp 1/1/0", ru_enable, poly_row, poly_col); end
    clear = 1;
    tick;
    clear = 0;
    total++;
    if ({busy, done, xof_start, xof_idx_x, xof_idx_y, ru_clear, ru_enable, poly_valid,
         poly_row, poly_col} !== 38'd0)
      begin bad++; $display("FAIL clear_outputs busy=%b en=%b row=%0d exp 0", busy, ru_enable, poly_row); end
    repeat (5) tick;
    total++;
    if (n_done !== 0 || busy !== 1'b0)
      begin bad++; $display("FAIL clear_no_done done=%0d busy=%b exp 0/0", n_done, busy); end
    run_matrix(1'b0, 0);
    total++;
    if (n_xs !== 4 || done_cyc !== 28 || hs_r[0] !== 8'd0 || hs_c[0] !== 8'd0 ||
        hs_r[3] !== 8'd1 || hs_c[3] !== 8'd1)
      begin bad++; $display("FAIL clear_restart xof=%0d cyc=%0d first=(%0d,%0d) exp 4/28/(0,0)", n_xs, done_cyc, hs_r[0], hs_c[0]); end
  endtask

  task automatic test_clear_start;
    tick;
    clr_mon();
    clear = 1; start = 1;
    tick;
    clear = 0; start = 0;
    total++;
    if (busy !== 1'b0)
      begin bad++; $display("FAIL clear_start_busy got=%b exp 0", busy); end
    repeat (3) tick;
    total++;
    if (n_xs !== 0 || busy !== 1'b0)
      begin bad++; $display("FAIL clear_start_idle xof=%0d busy=%b exp 0/0", n_xs, busy); end
  endtask

  task automatic test_glitch;
    glitch_en = 1;
    run_matrix(1'b0, 1);
    repeat (4) tick;
    glitch_en = 0;
    total++;
    if (n_xs !== 4 || n_hs !== 4 || n_done !== 1)
      begin bad++; $display("FAIL glitch_counts xof=%0d hs=%0d done=%0d exp 4/4/1", n_xs, n_hs, n_done); end
    total++;
    if (done_cyc !== 28 || hs_r[2] !== 8'd1 || hs_c[2] !== 8'd0)
      begin bad++; $display("FAIL glitch_order cyc=%0d hs2=(%0d,%0d) exp 28/(1,0)", done_cyc, hs_r[2], hs_c[2]); end
  endtask

  task automatic test_async_reset;
    tick;
    clr_mon();
    transposed = 0; start = 1;
    tick;
    start = 0;
    repeat (10) tick;
    reset_n = 0;
    #1;
    total++;
    if ({busy, done, xof_start, xof_idx_x, xof_idx_y, ru_clear, ru_enable, poly_valid,
         poly_row, poly_col} !== 38'd0)
      begin bad++; $display("FAIL async_reset busy=%b en=%b valid=%b exp 0", busy, ru_enable, poly_valid); end
    tick;
    reset_n = 1;
    tick;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_transposed();
    test_backpressure();
    test_latency_stale();
    test_clear();
    test_clear_start();
    test_glitch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
